mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
//
// PURPOSE
//   Shares the single Memory port (16-bit address, 32-bit data, sync write, comb read)
//   between the CPU datapath (MAR/Bus side) and a DMA/loader requester.
//   Round-robin arbitration, per-owner hold with a starvation limit, registered read return.
//   Sits between DataPath and the Memory instance; Memory ports connect 1:1 to Mem*.
//
// PARAMETERS
//   ADDR_W    16  memory address width
//   DATA_W    32  memory data width
//   MAX_HOLD  8   max consecutive accepted transfers by one owner while the other waits (>=1)
//
// PORTS
//   CLK        in   1       clock; all state updates on posedge
//   RST        in   1       synchronous, active-high reset
//   CpuReq     in   1       CPU requests a transfer; held until accepted
//   CpuWe      in   1       1 = write, 0 = read
//   CpuAddr    in   ADDR_W  CPU address
//   CpuWData   in   DATA_W  CPU write data
//   CpuGnt     out  1       transfer accepted this cycle (CpuReq && owner==CPU)
//   CpuRValid  out  1       CpuRData valid (1-cycle pulse)
//   CpuRData   out  DATA_W  registered read data
//   DmaReq/DmaWe/DmaAddr/DmaWData/DmaGnt/DmaRValid/DmaRData   same as Cpu*, for DMA
//   MemAddr    out  ADDR_W  to Memory.Address
//   MemWData   out  DATA_W  to Memory.In
//   MemWe      out  1       to Memory.Write
//   MemRData   in   DATA_W  from Memory.Out
//   Owner      out  2       00 IDLE, 01 CPU, 10 DMA (state register, for debug)
//
// BEHAVIOUR
//   - State: Owner in {IDLE, CPU, DMA}; LastOwner bit (0=CPU, 1=DMA); HoldCnt counter.
//   - Reset: Owner=IDLE, LastOwner=DMA (CPU wins first tie), HoldCnt=0, all Gnt/RValid=0,
//     RData=0, MemWe=0, MemAddr=0, MemWData=0. While RST=1, Gnt and MemWe are forced 0
//     (no write commits in the reset cycle, even if owner was mid-burst).
//   - Grant is combinational from the registered Owner: XGnt = XReq && Owner==X && !RST.
//   - Mem mux: MemAddr/MemWData from the owner's inputs; MemWe = owner's We && owner's Gnt.
//     When IDLE: MemAddr=0, MemWData=0, MemWe=0.
//   - Latency: Req rises in cycle n (Owner IDLE) -> Owner set at edge n -> Gnt in cycle n+1;
//     a write commits at edge n+1; read data captured from MemRData at edge n+1,
//     RValid=1 with RData in cycle n+2. Back-to-back accepted transfers: 1 per cycle.
//   - RData holds its last value when RValid=0; a write acceptance gives no RValid pulse.
//   - Transitions (evaluated each edge):
//       IDLE: only one Req -> that owner; both -> owner != LastOwner; none -> IDLE.
//       X owns: XReq=0 -> other if its Req=1, else IDLE.
//               XReq=1 and other Req=1 and HoldCnt==MAX_HOLD-1 on an accepted transfer -> other.
//               otherwise stay.
//     On entering an owner: LastOwner<=that owner, HoldCnt<=0.
//   - HoldCnt increments per accepted transfer only while the other requester is waiting;
//     resets to 0 when the other's Req is low; saturates, never wraps.
//   - Switching costs no bubble: handover edge moves Owner directly CPU<->DMA.
//   - A requester must keep Req/We/Addr/WData stable until its Gnt; dropping Req unaccepted
//     is legal and just forfeits the slot.
//
// TESTING
//   1 Reset: RST high 2 cycles with CpuReq=DmaReq=1 -> Owner=00, both Gnt=0, MemWe=0 throughout.
//   2 CPU read: Memory[0x0010]=0xDEADBEEF, CpuReq=1,We=0,Addr=0x0010 at cycle 0 -> CpuGnt cycle 1,
//     CpuRValid=1 with CpuRData=0xDEADBEEF in cycle 2, DmaRValid stays 0.
//   3 DMA write then CPU read same addr 0x0020, data 0x12345678 -> write commits, CPU reads 0x12345678.
//   4 Simultaneous Req from IDLE after reset -> CPU granted first; next tie from IDLE -> DMA.
//   5 Starvation: CPU Req held continuously, DMA Req raised, MAX_HOLD=8 -> exactly 8 CPU accepts
//     after DMA raised, then DmaGnt next cycle with no idle cycle between.
//   6 RST asserted in a cycle with CpuGnt write of 0xAAAA5555 to 0x0030 -> Memory[0x0030] unchanged.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// mem_port_arbiter_if : requester, memory and debug signals of the shared memory port | rev 1.0

interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              CpuReq;
  logic              CpuWe;
  logic [ADDR_W-1:0] CpuAddr;
  logic [DATA_W-1:0] CpuWData;
  logic              CpuGnt;
  logic              CpuRValid;
  logic [DATA_W-1:0] CpuRData;

  logic              DmaReq;
  logic              DmaWe;
  logic [ADDR_W-1:0] DmaAddr;
  logic [DATA_W-1:0] DmaWData;
  logic              DmaGnt;
  logic              DmaRValid;
  logic [DATA_W-1:0] DmaRData;

  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemWData;
  logic              MemWe;
  logic [DATA_W-1:0] MemRData;
  logic [1:0]        Owner;

  modport master (
    output CpuReq, CpuWe, CpuAddr, CpuWData,
    output DmaReq, DmaWe, DmaAddr, DmaWData,
    output MemRData,
    input  CpuGnt, CpuRValid, CpuRData,
    input  DmaGnt, DmaRValid, DmaRData,
    input  MemAddr, MemWData, MemWe, Owner
  );

  modport slave (
    input  CpuReq, CpuWe, CpuAddr, CpuWData,
    input  DmaReq, DmaWe, DmaAddr, DmaWData,
    input  MemRData,
    output CpuGnt, CpuRValid, CpuRData,
    output DmaGnt, DmaRValid, DmaRData,
    output MemAddr, MemWData, MemWe, Owner
  );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// mem_port_arbiter : round-robin CPU/DMA share of one memory port, hold limit, registered read return | rev 1.0

module mem_port_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 8
) (
  input  logic               CLK,
  input  logic               RST,
  mem_port_arbiter_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_CPU  = 2'b01;
  localparam logic [1:0] S_DMA  = 2'b10;

  localparam int              HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic [1:0]        r_owner;
  logic              r_last;      // 0 = CPU won last, 1 = DMA won last
  logic [HOLD_W-1:0] r_hold;
  logic              r_cpu_rvalid, r_dma_rvalid;
  logic [DATA_W-1:0] r_cpu_rdata,  r_dma_rdata;

  logic              w_cpu_gnt, w_dma_gnt;
  logic              w_own_req, w_oth_req;
  logic [1:0]        w_oth;
  logic [1:0]        w_next;
  logic [HOLD_W-1:0] w_hold_nxt;

  assign w_cpu_gnt = bus.CpuReq && (r_owner == S_CPU) && !RST;
  assign w_dma_gnt = bus.DmaReq && (r_owner == S_DMA) && !RST;

  always_comb begin
    bus.MemAddr  = '0;
    bus.MemWData = '0;
    case (r_owner)
      S_CPU: begin
        bus.MemAddr  = bus.CpuAddr;
        bus.MemWData = bus.CpuWData;
      end
      S_DMA: begin
        bus.MemAddr  = bus.DmaAddr;
        bus.MemWData = bus.DmaWData;
      end
      default: ;
    endcase
  end

  assign bus.MemWe = (w_cpu_gnt && bus.CpuWe) || (w_dma_gnt && bus.DmaWe);

  // View the current owner's request against the other side's, independent of who owns.
  always_comb begin
    w_own_req = 1'b0;
    w_oth_req = 1'b0;
    w_oth     = S_IDLE;
    case (r_owner)
      S_CPU: begin
        w_own_req = bus.CpuReq;
        w_oth_req = bus.DmaReq;
        w_oth     = S_DMA;
      end
      S_DMA: begin
        w_own_req = bus.DmaReq;
        w_oth_req = bus.CpuReq;
        w_oth     = S_CPU;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_next     = r_owner;
    w_hold_nxt = r_hold;
    case (r_owner)
      S_IDLE: begin
        if (bus.CpuReq && bus.DmaReq) w_next = r_last ? S_CPU : S_DMA;
        else if (bus.CpuReq)          w_next = S_CPU;
        else if (bus.DmaReq)          w_next = S_DMA;
      end
      S_CPU, S_DMA: begin
        if (!w_own_req) begin
          w_next = w_oth_req ? w_oth : S_IDLE;
        end else if (w_oth_req) begin
          if (r_hold == HOLD_LAST) w_next = w_oth;
          else                     w_hold_nxt = r_hold + 1'b1;
        end else begin
          w_hold_nxt = '0;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_owner <= S_IDLE;
      r_last  <= 1'b1;
      r_hold  <= '0;
    end else begin
      r_owner <= w_next;
      if (w_next != r_owner && w_next != S_IDLE) begin
        r_last <= (w_next == S_DMA);
        r_hold <= '0;
      end else begin
        r_hold <= w_hold_nxt;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cpu_rvalid <= 1'b0;
      r_dma_rvalid <= 1'b0;
      r_cpu_rdata  <= '0;
      r_dma_rdata  <= '0;
    end else begin
      r_cpu_rvalid <= w_cpu_gnt && !bus.CpuWe;
      r_dma_rvalid <= w_dma_gnt && !bus.DmaWe;
      if (w_cpu_gnt && !bus.CpuWe) r_cpu_rdata <= bus.MemRData;
      if (w_dma_gnt && !bus.DmaWe) r_dma_rdata <= bus.MemRData;
    end
  end

  assign bus.CpuGnt    = w_cpu_gnt;
  assign bus.DmaGnt    = w_dma_gnt;
  assign bus.CpuRValid = r_cpu_rvalid;
  assign bus.DmaRValid = r_dma_rvalid;
  assign bus.CpuRData  = r_cpu_rdata;
  assign bus.DmaRData  = r_dma_rdata;
  assign bus.Owner     = r_owner;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// tb_mem_port_arbiter : directed scenarios plus random traffic against a transaction-level arbiter model | rev 1.0

module tb_mem_port_arbiter;
  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 32;
  localparam int MAX_HOLD = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  // Memory instance stand-in: synchronous write, combinational read.
  bit [31:0] env_mem [0:255];
  assign bus.MemRData = env_mem[bus.MemAddr[7:0]];
  always @(posedge clk) if (bus.MemWe) env_mem[bus.MemAddr[7:0]] <= bus.MemWData;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: owner 0 idle / 1 CPU / 2 DMA, streak = accepts while the other waits.
  int          m_owner  = 0;
  int          m_last   = 2;
  int          m_streak = 0;
  bit          m_rv [1:2];
  logic [31:0] m_rd [1:2];
  logic [31:0] m_mem [int];

  initial begin
    m_rv[1] = 0; m_rv[2] = 0;
    m_rd[1] = 0; m_rd[2] = 0;
  end

  function automatic logic [31:0] m_read(input logic [15:0] a);
    return m_mem.exists(int'(a)) ? m_mem[int'(a)] : 32'h0;
  endfunction

  always @(negedge clk) begin : cmp
    bit          req [1:2];
    bit          we  [1:2];
    logic [15:0] ad  [1:2];
    logic [31:0] wd  [1:2];
    bit          gnt [1:2];
    int          nxt, me, oth;
    req[1] = bus.CpuReq; we[1] = bus.CpuWe; ad[1] = bus.CpuAddr; wd[1] = bus.CpuWData;
    req[2] = bus.DmaReq; we[2] = bus.DmaWe; ad[2] = bus.DmaAddr; wd[2] = bus.DmaWData;
    gnt[1] = !rst && req[1] && m_owner == 1;
    gnt[2] = !rst && req[2] && m_owner == 2;

    chk("cmp_cpu_gnt",  32'(bus.CpuGnt), 32'(gnt[1]));
    chk("cmp_dma_gnt",  32'(bus.DmaGnt), 32'(gnt[2]));
    chk("cmp_mem_we",   32'(bus.MemWe),  32'((gnt[1] && we[1]) || (gnt[2] && we[2])));
    chk("cmp_mem_addr", 32'(bus.MemAddr),  m_owner == 0 ? 32'h0 : 32'(ad[m_owner]));
    chk("cmp_mem_wdat", bus.MemWData,      m_owner == 0 ? 32'h0 : wd[m_owner]);
    chk("cmp_owner",    32'(bus.Owner),  32'(m_owner));
    chk("cmp_cpu_rv",   32'(bus.CpuRValid), 32'(m_rv[1]));
    chk("cmp_dma_rv",   32'(bus.DmaRValid), 32'(m_rv[2]));
    chk("cmp_cpu_rd",   bus.CpuRData, m_rd[1]);
    chk("cmp_dma_rd",   bus.DmaRData, m_rd[2]);

    if (rst) begin
      m_owner = 0; m_last = 2; m_streak = 0;
      m_rv[1] = 0; m_rv[2] = 0; m_rd[1] = 0; m_rd[2] = 0;
    end else begin
      for (int r = 1; r <= 2; r++) begin
        m_rv[r] = gnt[r] && !we[r];
        if (m_rv[r]) m_rd[r] = m_read(ad[r]);
      end
      for (int r = 1; r <= 2; r++)
        if (gnt[r] && we[r]) m_mem[int'(ad[r])] = wd[r];

      if (m_owner == 0) begin
        if (req[1] && req[2]) nxt = (m_last == 1) ? 2 : 1;
        else if (req[1])      nxt = 1;
        else if (req[2])      nxt = 2;
        else                  nxt = 0;
      end else begin
        me  = m_owner;
        oth = 3 - m_owner;
        if (!req[me]) nxt = req[oth] ? oth : 0;
        else if (req[oth]) begin
          m_streak++;
          nxt = (m_streak >= MAX_HOLD) ? oth : me;
        end else begin
          m_streak = 0;
          nxt = me;
        end
      end
      if (nxt != 0 && nxt != m_owner) begin
        m_last   = nxt;
        m_streak = 0;
      end
      m_owner = nxt;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input bit dma, input bit we, input logic [15:0] a,
                      input logic [31:0] d, output int lat);
    bit got = 0;
    lat = -1;
    if (dma) begin
      bus.DmaReq = 1; bus.DmaWe = we; bus.DmaAddr = a; bus.DmaWData = d;
    end else begin
      bus.CpuReq = 1; bus.CpuWe = we; bus.CpuAddr = a; bus.CpuWData = d;
    end
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if ((dma ? bus.DmaGnt : bus.CpuGnt) === 1'b1) begin
        got = 1;
        lat = k;
      end
      next_cycle();
    end
    if (!got) chk("xfer_timeout", 32'h0, 32'h1);
    if (dma) bus.DmaReq = 0; else bus.CpuReq = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat, cnt;
    bit  seen, prevc, gapok, gc, gd;
    rst = 1;
    bus.CpuReq = 1; bus.CpuWe = 0; bus.CpuAddr = '0; bus.CpuWData = '0;
    bus.DmaReq = 1; bus.DmaWe = 0; bus.DmaAddr = '0; bus.DmaWData = '0;

    repeat (2) begin
      @(negedge clk);
      chk("rst_owner",  32'(bus.Owner),  32'h0);
      chk("rst_cpugnt", 32'(bus.CpuGnt), 32'h0);
      chk("rst_dmagnt", 32'(bus.DmaGnt), 32'h0);
      chk("rst_memwe",  32'(bus.MemWe),  32'h0);
    end
    next_cycle();
    rst = 0; bus.CpuReq = 0; bus.DmaReq = 0;
    next_cycle();

    // Ties from IDLE: CPU first after reset, then DMA.
    bus.CpuReq = 1; bus.CpuAddr = 16'h1;
    bus.DmaReq = 1; bus.DmaAddr = 16'h2;
    next_cycle();
    @(negedge clk);
    chk("tie1_cpu", 32'(bus.CpuGnt), 32'h1);
    chk("tie1_dma", 32'(bus.DmaGnt), 32'h0);
    next_cycle();
    bus.CpuReq = 0; bus.DmaReq = 0;
    next_cycle();
    bus.CpuReq = 1; bus.DmaReq = 1;
    next_cycle();
    @(negedge clk);
    chk("tie2_dma", 32'(bus.DmaGnt), 32'h1);
    chk("tie2_cpu", 32'(bus.CpuGnt), 32'h0);
    next_cycle();
    bus.CpuReq = 0; bus.DmaReq = 0;
    repeat (2) next_cycle();

    // CPU write then read back, with grant latency from IDLE and back-to-back.
    xfer(0, 1, 16'h0010, 32'hDEADBEEF, lat);
    chk("gnt_latency", 32'(lat), 32'h1);
    xfer(0, 0, 16'h0010, 32'h0, lat);
    chk("b2b_latency", 32'(lat), 32'h0);
    @(negedge clk);
    chk("rd_cpu_rv",   32'(bus.CpuRValid), 32'h1);
    chk("rd_cpu_data", bus.CpuRData, 32'hDEADBEEF);
    chk("rd_dma_rv",   32'(bus.DmaRValid), 32'h0);
    next_cycle();

    // DMA write, CPU reads the same location.
    xfer(1, 1, 16'h0020, 32'h12345678, lat);
    xfer(0, 0, 16'h0020, 32'h0, lat);
    @(negedge clk);
    chk("dma_wr_cpu_rd", bus.CpuRData, 32'h12345678);
    next_cycle();
    repeat (2) next_cycle();

    // Starvation limit.
    bus.CpuReq = 1; bus.CpuWe = 0; bus.CpuAddr = 16'h5;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = bus.CpuGnt;
      next_cycle();
    end
    bus.DmaReq = 1; bus.DmaWe = 1; bus.DmaAddr = 16'h6; bus.DmaWData = 32'h0BADF00D;
    cnt = 0; seen = 0; prevc = 0; gapok = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (bus.DmaGnt) begin
        seen  = 1;
        gapok = prevc;
      end else begin
        if (bus.CpuGnt) cnt++;
        prevc = bus.CpuGnt;
      end
      next_cycle();
    end
    chk("starve_dma_seen", 32'(seen),  32'h1);
    chk("starve_cpu_cnt",  32'(cnt),   32'(MAX_HOLD));
    chk("starve_no_gap",   32'(gapok), 32'h1);
    bus.CpuReq = 0; bus.DmaReq = 0;
    repeat (2) next_cycle();

    // Reset lands in the cycle the CPU write would be granted.
    bus.CpuReq = 1; bus.CpuWe = 1; bus.CpuAddr = 16'h0030; bus.CpuWData = 32'hAAAA5555;
    next_cycle();
    rst = 1;
    @(negedge clk);
    chk("rstwr_gnt",   32'(bus.CpuGnt), 32'h0);
    chk("rstwr_memwe", 32'(bus.MemWe),  32'h0);
    next_cycle();
    rst = 0; bus.CpuReq = 0;
    next_cycle();
    chk("rstwr_mem", env_mem[8'h30], 32'h0);
    xfer(0, 0, 16'h0030, 32'h0, lat);
    @(negedge clk);
    chk("rstwr_readback", bus.CpuRData, 32'h0);
    next_cycle();

    // Random traffic; requests stay stable until granted or deliberately dropped.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      gc = bus.CpuGnt;
      gd = bus.DmaGnt;
      next_cycle();
      rst = ($urandom_range(0, 299) == 0);
      if (bus.CpuReq && !gc) begin
        if ($urandom_range(0, 15) == 0) bus.CpuReq = 0;
      end else begin
        bus.CpuReq   = ($urandom_range(0, 3) != 0);
        bus.CpuWe    = 1'($urandom_range(0, 1));
        bus.CpuAddr  = 16'($urandom_range(0, 15));
        bus.CpuWData = $urandom;
      end
      if (bus.DmaReq && !gd) begin
        if ($urandom_range(0, 15) == 0) bus.DmaReq = 0;
      end else begin
        bus.DmaReq   = ($urandom_range(0, 3) != 0);
        bus.DmaWe    = 1'($urandom_range(0, 1));
        bus.DmaAddr  = 16'($urandom_range(0, 15));
        bus.DmaWData = $urandom;
      end
    end
    rst = 0; bus.CpuReq = 0; bus.DmaReq = 0;
    repeat (3) next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
